// File: rtl/result_fifo.sv
// result_fifo: first-word-fall-through buffer between the convolver datapath
// and the AHB-Lite slave. The head entry is presented combinationally on
// result_out; sticky overrun/underrun flags report dropped pushes and
// pops requested while empty.
module result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     read_enable,
    output logic [WIDTH-1:0]         result_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    output logic                     underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             push_acc;
    logic             pop_acc;

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign count = cnt;

    // A push into a full FIFO is still taken when a pop frees the head slot
    // in the same cycle; pops are never taken while empty.
    assign push_acc = wr_en && (!full || read_enable);
    assign pop_acc  = read_enable && !empty;

    // Head entry is driven from registered state only, zero while empty.
    assign result_out = empty ? '0 : mem[rp];

    // Storage array: written on accepted pushes, never reset or flushed.
    always_ff @(posedge clk) begin
        if (push_acc && !clear) begin
            mem[wp] <= wr_data;
        end
    end

    // Pointers, occupancy and sticky error flags; clear overrides all traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else if (clear) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (push_acc) begin
                wp <= wp + AW'(1);
            end
            if (pop_acc) begin
                rp <= rp + AW'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (wr_en && full && !read_enable) begin
                overrun <= 1'b1;
            end
            if (read_enable && empty) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_fifo.sv
// tb_result_fifo: directed scenarios followed by random traffic. A queue-based
// reference model tracks the expected contents and flags at every clock edge;
// a separate monitor compares all DUT outputs against it on each falling edge.
module tb_result_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   clear = 1'b0;
    logic                   wr_en = 1'b0;
    logic [WIDTH-1:0]       wr_data = '0;
    logic                   read_enable = 1'b0;
    logic [WIDTH-1:0]       result_out;
    logic                   empty;
    logic                   full;
    logic [$clog2(DEPTH):0] count;
    logic                   overrun;
    logic                   underrun;

    int checks = 0;
    int failures = 0;
    int pops_seen = 0;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    bit               m_ovr = 0;
    bit               m_udr = 0;

    result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .read_enable (read_enable),
        .result_out  (result_out),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: FIFO as a queue, updated from the inputs seen at each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ovr = 0;
            m_udr = 0;
        end else if (clear) begin
            q.delete();
            m_ovr = 0;
            m_udr = 0;
        end else begin
            int  sz;
            bit  do_pop;
            bit  do_push;
            sz      = q.size();
            do_pop  = read_enable && (sz > 0);
            do_push = wr_en && ((sz < DEPTH) || read_enable);
            if (wr_en && !read_enable && sz == DEPTH) m_ovr = 1;
            if (read_enable && sz == 0) m_udr = 1;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(wr_data);
        end
    end

    // Monitor: compare every observable output against the model mid-cycle.
    always @(negedge clk) begin
        logic [WIDTH-1:0] exp_head;
        exp_head = (q.size() > 0) ? q[0] : '0;
        if (read_enable && q.size() > 0) begin
            pops_seen++;
            chk("pop_data", 32'(result_out), 32'(exp_head));
        end else begin
            chk("head", 32'(result_out), 32'(exp_head));
        end
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("underrun", 32'(underrun), 32'(m_udr));
    end

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc(input bit we, input logic [WIDTH-1:0] wd, input bit re, input bit clr);
        wr_en       = we;
        wr_data     = wd;
        read_enable = re;
        clear       = clr;
        @(posedge clk);
        #1;
        wr_en       = 1'b0;
        read_enable = 1'b0;
        clear       = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        // Reset held: outputs at their reset values
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_result", 32'(result_out), 32'd0);
        chk("rst_flags", 32'({overrun, underrun}), 32'd0);
        rst = 1'b0;
        cyc(0, '0, 0, 0);

        // Single entry
        cyc(1, 16'h1234, 0, 0);
        chk("single_head", 32'(result_out), 32'h1234);
        chk("single_count", 32'(count), 32'd1);
        cyc(0, '0, 1, 0);
        chk("single_after_empty", 32'(empty), 32'd1);
        chk("single_after_result", 32'(result_out), 32'd0);

        // Fill and overrun
        for (int i = 1; i <= 8; i++) cyc(1, 16'(i), 0, 0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd8);
        cyc(1, 16'h0009, 0, 0);
        chk("fill_overrun", 32'(overrun), 32'd1);
        chk("fill_count_after_drop", 32'(count), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", 32'(result_out), 32'(i));
            cyc(0, '0, 1, 0);
        end
        chk("drain_overrun_sticky", 32'(overrun), 32'd1);

        // Simultaneous push and pop while full
        cyc(0, '0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(1, 16'(16'h0010 + i), 0, 0);
        cyc(1, 16'h00AA, 1, 0);
        chk("simul_count", 32'(count), 32'd8);
        chk("simul_overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("simul_drain", 32'(result_out), (i < 7) ? 32'(16'h0011 + i) : 32'h00AA);
            cyc(0, '0, 1, 0);
        end

        // Underrun and push into empty
        cyc(0, '0, 1, 0);
        chk("udr_flag", 32'(underrun), 32'd1);
        chk("udr_count", 32'(count), 32'd0);
        cyc(1, 16'h5555, 1, 0);
        chk("udr_push_count", 32'(count), 32'd1);
        chk("udr_push_result", 32'(result_out), 32'h5555);

        // Clear with a concurrent push discards the push and the flags
        cyc(1, 16'h0BAD, 0, 0);
        cyc(1, 16'h7777, 0, 1);
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_flags", 32'({overrun, underrun}), 32'd0);
        chk("clear_result", 32'(result_out), 32'd0);

        // Pointer wrap: 5 in/out, then 8 in/out
        for (int i = 0; i < 5; i++) cyc(1, 16'(16'hA000 + i), 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(1, 16'(16'hB000 + i), 0, 0);
        chk("wrap_full", 32'(full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_order", 32'(result_out), 32'(16'hB000 + i));
            cyc(0, '0, 1, 0);
        end

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) < 55), 16'($urandom), ($urandom_range(0, 99) < 45),
                ($urandom_range(0, 199) == 0));
        end

        // Asynchronous reset in the middle of a drain
        cyc(0, '0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 16'(16'hC000 + i), 0, 0);
        cyc(0, '0, 1, 0);
        wr_en = 1'b1;
        wr_data = 16'hDEAD;
        read_enable = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_result", 32'(result_out), 32'd0);
        chk("arst_flags", 32'({overrun, underrun}), 32'd0);
        wr_en = 1'b0;
        read_enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, '0, 0, 0);
        cyc(1, 16'h4242, 0, 0);
        chk("post_rst_head", 32'(result_out), 32'h4242);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);

        chk("pops_observed", 32'(pops_seen > 100), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
